// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads one big-endian 32-bit word per cycle
// from the instruction memory and presents it to decode through a small prefetch queue.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_BYTES = 4096,
    parameter int          QDEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        pc_load,
    input  logic [31:0] pc_load_val,
    output logic [31:0] IM_Address,
    output logic        IM_cs,
    output logic        IM_rd,
    output logic        IM_wr,
    output logic [31:0] IM_D_in,
    input  logic [31:0] IM_D_out,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    output logic [31:0] pc
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);
    // Keeps addresses word aligned and inside the memory, giving the modulo wrap for free.
    localparam logic [31:0] ADDR_MASK = 32'(MEM_BYTES - 1) & ~32'd3;

    typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [31:0]      q_ir [QDEPTH];
    logic [31:0]      q_pc [QDEPTH];
    logic             full;
    logic             pop;
    logic             fetch;

    assign full     = (count == FULL_CNT);
    assign ir_valid = (count != '0);
    assign pop      = ir_valid & ir_ready;
    assign ir       = ir_valid ? q_ir[head] : 32'h0;
    assign ir_pc    = ir_valid ? q_pc[head] : 32'h0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (!en) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    state_next = RUN;
                RUN:     if (full && !pop && !pc_load) state_next = STALL;
                STALL:   if (pop || pc_load) state_next = RUN;
                default: state_next = IDLE;
            endcase
        end
    end

    // Reset gates the strobes so they drop the moment reset rises, not at the next edge.
    always_comb begin
        fetch      = !reset && en && !pc_load && (!full || pop);
        IM_cs      = fetch;
        IM_rd      = fetch;
        IM_Address = pc;
        IM_wr      = 1'b0;
        IM_D_in    = 32'h0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc    <= RESET_PC;
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else if (pc_load) begin
            pc    <= pc_load_val & ADDR_MASK;
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else begin
            if (fetch) begin
                pc   <= (pc + 32'd4) & ADDR_MASK;
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            case ({fetch, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Queue storage carries no reset; ir/ir_pc are masked to zero whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (fetch) begin
            q_ir[tail] <= IM_D_out;
            q_pc[tail] <= pc;
        end
    end

endmodule
